instr_encoder: RTL and testbench

RV32I instruction encoder: converts field-level instruction requests (class, funct3, alt bit, register numbers, immediate) into 32-bit machine words and streams them, tagged with sequential instruction-memory addresses, to the program loader / instruction-memory write port. It is the inverse of the core's instruction decoder, and is used by the self-test program generator and the boot loader. It is a one-stage registered pipeline with a skid entry on a valid/ready interface on both sides.

---
 rtl/instr_encoder_pkg.sv | 45 ++++
 rtl/instr_pack.sv | 84 ++++++++
 rtl/instr_encoder.sv | 147 ++++++++++++++
 tb/tb_instr_encoder.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// rtl/instr_encoder_pkg.sv - RV32I encoder class codes, opcodes and helpers
//
// Purpose: shared constants for instr_pack and instr_encoder.
//   - instr_class_e : request class codes 0..8 (9..15 are illegal)
//   - OPC_*         : 7-bit major opcodes
//   - NOP_WORD      : addi x0,x0,0, emitted for illegal classes
//   - fits_signed() : true when a 32-bit value is representable as a
//                     two's-complement number of the given width
// Ports: none (package).

package instr_encoder_pkg;

  typedef enum logic [3:0] {
    CLS_OP     = 4'd0,
    CLS_OPIMM  = 4'd1,
    CLS_LUI    = 4'd2,
    CLS_AUIPC  = 4'd3,
    CLS_JAL    = 4'd4,
    CLS_JALR   = 4'd5,
    CLS_BRANCH = 4'd6,
    CLS_LOAD   = 4'd7,
    CLS_STORE  = 4'd8
  } instr_class_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Every bit from the sign position of a bits-wide field upward must equal
  // bit 31; folding with the sign bit turns that into an "all zero" test.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic [31:0] folded;
    folded = v ^ {32{v[31]}};
    return (folded >> (bits - 1)) == 32'd0;
  endfunction

endpackage

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational RV32I field packer and legality checker
//
// Purpose: packs one field-level request into a 32-bit RV32I word and flags
//   illegal requests. Illegal classes always produce NOP_WORD.
// Macro: ENC_RANGE_CHECK_EN enables the legality checks; when undefined
//   err is tied to 0 and immediates are silently truncated.
// Ports:
//   cls    in  4   request class (instr_class_e, 9..15 illegal)
//   funct3 in  3   funct3 field
//   alt    in  1   funct7[5] (SUB/SRA/SRAI)
//   rd     in  5   destination register
//   rs1    in  5   source register 1
//   rs2    in  5   source register 2
//   imm    in  32  sign-extended immediate (full value for LUI/AUIPC)
//   word   out 32  packed instruction
//   err    out 1   request failed a legality check

module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        err
);

  logic is_shift;
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    word = NOP_WORD;
    case (cls)
      CLS_OP:     word = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, OPC_OP};
      CLS_OPIMM: begin
        if (is_shift) word = {1'b0, alt, 5'b0, imm[4:0], rs1, funct3, rd, OPC_OPIMM};
        else          word = {imm[11:0], rs1, funct3, rd, OPC_OPIMM};
      end
      CLS_LUI:    word = {imm[31:12], rd, OPC_LUI};
      CLS_AUIPC:  word = {imm[31:12], rd, OPC_AUIPC};
      CLS_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      CLS_JALR:   word = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
      CLS_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
      CLS_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
      default:    word = NOP_WORD;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic bad;

  always_comb begin
    bad = 1'b0;
    case (cls)
      // funct7[5] is only meaningful for SUB (000) and SRA (101).
      CLS_OP:     bad = alt && !((funct3 == 3'b000) || (funct3 == 3'b101));
      CLS_OPIMM: begin
        if (is_shift) bad = (imm[31:5] != 27'd0) || (alt && (funct3 == 3'b001));
        else          bad = !fits_signed(imm, 12) || alt;
      end
      CLS_LUI,
      CLS_AUIPC:  bad = (imm[11:0] != 12'd0) || alt;
      CLS_JAL:    bad = !fits_signed(imm, 21) || imm[0] || alt;
      CLS_JALR:   bad = !fits_signed(imm, 12) || alt;
      CLS_BRANCH: bad = !fits_signed(imm, 13) || imm[0] || alt ||
                        (funct3 == 3'b010) || (funct3 == 3'b011);
      CLS_LOAD:   bad = !fits_signed(imm, 12) || alt ||
                        (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      CLS_STORE:  bad = !fits_signed(imm, 12) || alt || (funct3 > 3'b010);
      default:    bad = 1'b1;
    endcase
  end

  assign err = bad;
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction encoder with skid pipeline and address counter
//
// Purpose: encodes field-level requests via instr_pack and streams words,
//   tagged with sequential addresses, through a one-stage registered pipeline
//   with a single skid entry. Legality checking depends on ENC_RANGE_CHECK_EN
//   (see instr_pack).
// Parameters: ADDR_W (address width), BASE_ADDR (first address, multiple of 4).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               sync: address -> BASE_ADDR, err_count -> 0
//   in_valid/in_ready   request handshake (in_ready registered)
//   in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm  request fields
//   out_valid/out_ready word handshake
//   out_word, out_addr, out_err  encoded word, its address, legality flag
//   err_count           saturating count of words emitted with out_err

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_alt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  logic [31:0] pack_word;
  logic        pack_err;

  instr_pack u_pack (
    .cls    (in_class),
    .funct3 (in_funct3),
    .alt    (in_alt),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .word   (pack_word),
    .err    (pack_err)
  );

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_word_q,  out_word_d;
  logic              out_err_q,   out_err_d;
  logic              skid_valid_q, skid_valid_d;
  logic [31:0]       skid_word_q, skid_word_d;
  logic              skid_err_q,  skid_err_d;
  logic              in_ready_q,  in_ready_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [7:0]        err_cnt_q,   err_cnt_d;

  logic in_hs, out_hs;
  assign in_hs  = in_valid & in_ready_q;
  assign out_hs = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_word_d  = skid_word_q;
    skid_err_d   = skid_err_q;
    addr_d       = addr_q;
    err_cnt_d    = err_cnt_q;

    if (!out_valid_q || out_ready) begin
      // Output register is free or draining this cycle. A held skid entry
      // always goes first; in_ready is low then, so no new request competes.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_word_d   = skid_word_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (in_hs) begin
        out_valid_d = 1'b1;
        out_word_d  = pack_word;
        out_err_d   = pack_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_hs) begin
      skid_valid_d = 1'b1;
      skid_word_d  = pack_word;
      skid_err_d   = pack_err;
    end

    in_ready_d = !skid_valid_d;

    // out_addr is the counter itself, so it stays put while a word stalls.
    if (clear)       addr_d = BASE;
    else if (out_hs) addr_d = addr_q + ADDR_STEP;

    if (clear)                                       err_cnt_d = 8'd0;
    else if (out_hs && out_err_q && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_word_q   <= 32'd0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_word_q  <= 32'd0;
      skid_err_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      addr_q       <= BASE;
      err_cnt_q    <= 8'd0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_word_q  <= skid_word_d;
      skid_err_q   <= skid_err_d;
      in_ready_q   <= in_ready_d;
      addr_q       <= addr_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_err   = out_err_q;
  assign out_addr  = addr_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder

module tb_instr_encoder;

`ifdef ENC_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct {
    logic [31:0] word;
    logic        err;
  } exp_t;

  logic        clk, rst_n, clear;
  logic        in_valid, in_ready;
  logic [3:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_alt;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid, out_ready;
  logic [31:0] out_word;
  logic [3:0]  out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_funct3 (in_funct3),
    .in_alt    (in_alt),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] fld(input logic [31:0] x, input int hi, input int lo);
    logic [31:0] m;
    m = (32'd1 << (hi - lo + 1)) - 32'd1;
    return (x >> lo) & m;
  endfunction

  function automatic exp_t model(input req_t r);
    exp_t        o;
    logic [31:0] u, rd, rs1, rs2, f3, alt;
    int          s;
    bit          bad, i_bad;
    u = r.imm; s = $signed(r.imm);
    rd = {27'd0, r.rd}; rs1 = {27'd0, r.rs1}; rs2 = {27'd0, r.rs2};
    f3 = {29'd0, r.f3}; alt = {31'd0, r.alt};
    i_bad = (s < -2048) || (s > 2047);
    bad = 1'b0;
    o.word = 32'h13;
    case (r.cls)
      4'd0: begin
        o.word = (alt << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
        bad = r.alt && !(r.f3 == 3'd0 || r.f3 == 3'd5);
      end
      4'd1: begin
        if (r.f3 == 3'd1 || r.f3 == 3'd5) begin
          o.word = (alt << 30) | (fld(u, 4, 0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
          bad = (s < 0) || (s > 31) || (r.alt && r.f3 == 3'd1);
        end else begin
          o.word = (fld(u, 11, 0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
          bad = i_bad || r.alt;
        end
      end
      4'd2, 4'd3: begin
        o.word = (u & 32'hFFFF_F000) | (rd << 7) | ((r.cls == 4'd2) ? 32'h37 : 32'h17);
        bad = (fld(u, 11, 0) != 0) || r.alt;
      end
      4'd4: begin
        o.word = (fld(u, 20, 20) << 31) | (fld(u, 10, 1) << 21) | (fld(u, 11, 11) << 20) |
                 (fld(u, 19, 12) << 12) | (rd << 7) | 32'h6F;
        bad = u[0] || (s < -1048576) || (s > 1048574) || r.alt;
      end
      4'd5: begin
        o.word = (fld(u, 11, 0) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
        bad = i_bad || r.alt;
      end
      4'd6: begin
        o.word = (fld(u, 12, 12) << 31) | (fld(u, 10, 5) << 25) | (rs2 << 20) | (rs1 << 15) |
                 (f3 << 12) | (fld(u, 4, 1) << 8) | (fld(u, 11, 11) << 7) | 32'h63;
        bad = u[0] || (s < -4096) || (s > 4094) || r.f3 == 3'd2 || r.f3 == 3'd3 || r.alt;
      end
      4'd7: begin
        o.word = (fld(u, 11, 0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
        bad = i_bad || r.alt || r.f3 == 3'd3 || r.f3 == 3'd6 || r.f3 == 3'd7;
      end
      4'd8: begin
        o.word = (fld(u, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                 (fld(u, 4, 0) << 7) | 32'h23;
        bad = i_bad || r.alt || r.f3 > 3'd2;
      end
      default: begin
        o.word = 32'h13;
        bad = 1'b1;
      end
    endcase
    o.err = CHK ? bad : 1'b0;
    return o;
  endfunction

  function automatic req_t mk(input int cls, input int f3, input int alt, input int rd,
                              input int rs1, input int rs2, input logic [31:0] imm);
    req_t r;
    r.cls = 4'(cls); r.f3 = 3'(f3); r.alt = 1'(alt);
    r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = imm;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.cls = 4'($urandom_range(0, 15));
    r.f3  = 3'($urandom_range(0, 7));
    r.alt = ($urandom_range(0, 3) == 0);
    r.rd  = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
    case ($urandom_range(0, 3))
      0:       r.imm = 32'($signed($urandom_range(0, 64)) - 32);
      1:       r.imm = 32'($signed($urandom_range(0, 10000)) - 5000);
      2:       r.imm = $urandom;
      default: r.imm = $urandom & 32'hFFFF_F000;
    endcase
    return r;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input req_t r);
    in_class = r.cls; in_funct3 = r.f3; in_alt = r.alt;
    in_rd = r.rd; in_rs1 = r.rs1; in_rs2 = r.rs2; in_imm = r.imm;
  endtask

  // Called at a negedge; returns at the negedge after the request is taken.
  task automatic send_req(input req_t r);
    int  t;
    bit  acc;
    t = 0;
    drive(r);
    in_valid = 1'b1;
    forever begin
      acc = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) break;
      t++;
      if (t > 50) begin
        n_checks++; n_fail++;
        $display("FAIL send_timeout: in_ready stayed %0b, required 1 within 50 cycles", in_ready);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 32'd0));
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_word !== 32'd0) begin n_fail++; $display("FAIL reset_out_word: got %h want 0", out_word); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    n_checks++; if (out_addr !== 4'd0) begin n_fail++; $display("FAIL reset_out_addr: got %h want 0", out_addr); end
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_addi();
    do_clear();
    out_ready = 1'b1;
    send_req(mk(1, 0, 0, 1, 2, 0, 32'hFFFF_FFFF));
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    n_checks++; if (out_word !== 32'hFFF1_0093) begin n_fail++; $display("FAIL addi_word: got %h want fff10093", out_word); end
    n_checks++; if (out_addr !== 4'h0) begin n_fail++; $display("FAIL addi_addr: got %h want 0", out_addr); end
    n_checks++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL addi_err: got %b want 0", out_err); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    out_ready = 1'b1;
    send_req(mk(0, 0, 1, 3, 1, 2, 32'd0));
    n_checks++; if (out_word !== 32'h4020_81B3 || out_addr !== 4'h0)
      begin n_fail++; $display("FAIL sub_word: got %h@%h want 402081b3@0", out_word, out_addr); end
    send_req(mk(6, 0, 0, 0, 1, 2, 32'd8));
    n_checks++; if (out_valid !== 1'b1 || out_word !== 32'h0020_8463 || out_addr !== 4'h4)
      begin n_fail++; $display("FAIL beq_word: got v%b %h@%h want 00208463@4", out_valid, out_word, out_addr); end
    @(negedge clk);
  endtask

  task automatic test_lui();
    do_clear();
    out_ready = 1'b1;
    send_req(mk(2, 0, 0, 5, 0, 0, 32'h1234_5000));
    n_checks++; if (out_word !== 32'h1234_52B7 || out_err !== 1'b0)
      begin n_fail++; $display("FAIL lui_word: got %h err %b want 123452b7 err 0", out_word, out_err); end
    send_req(mk(2, 0, 0, 5, 0, 0, 32'h1234_5001));
    n_checks++; if (out_word !== 32'h1234_52B7 || out_err !== CHK)
      begin n_fail++; $display("FAIL lui_bad: got %h err %b want 123452b7 err %b", out_word, out_err, CHK); end
    @(negedge clk);
    n_checks++; if (err_count !== (CHK ? 8'd1 : 8'd0))
      begin n_fail++; $display("FAIL lui_err_count: got %0d want %0d", err_count, CHK ? 1 : 0); end
  endtask

  task automatic test_backpressure();
    exp_t ea, eb, ec;
    req_t ra, rb, rc;
    ra = mk(1, 0, 0, 1, 0, 0, 32'd11);
    rb = mk(1, 0, 0, 2, 0, 0, 32'd22);
    rc = mk(1, 0, 0, 3, 0, 0, 32'd33);
    ea = model(ra); eb = model(rb); ec = model(rc);
    do_clear();
    out_ready = 1'b0;
    drive(ra); in_valid = 1'b1;
    @(negedge clk);
    drive(rb);
    @(negedge clk);
    drive(rc);
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_drop: got %b want 0", in_ready); end
    repeat (2) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0 || out_word !== ea.word || out_addr !== 4'h0)
      begin n_fail++; $display("FAIL bp_hold: rdy %b %h@%h want rdy 0 %h@0", in_ready, out_word, out_addr, ea.word); end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1 || out_word !== eb.word || out_addr !== 4'h4 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL bp_second: v%b %h@%h rdy %b want %h@4 rdy 1", out_valid, out_word, out_addr, in_ready, eb.word); end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_word !== ec.word || out_addr !== 4'h8)
      begin n_fail++; $display("FAIL bp_third: v%b %h@%h want %h@8", out_valid, out_word, out_addr, ec.word); end
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_errors();
    exp_t eb;
    eb = model(mk(6, 0, 0, 0, 1, 2, 32'd4097));
    do_clear();
    out_ready = 1'b1;
    send_req(mk(6, 0, 0, 0, 1, 2, 32'd4097));
    n_checks++; if (out_word !== eb.word || out_err !== CHK)
      begin n_fail++; $display("FAIL branch_range: got %h err %b want %h err %b", out_word, out_err, eb.word, CHK); end
    send_req(mk(12, 0, 0, 7, 7, 7, 32'd5));
    n_checks++; if (out_word !== 32'h0000_0013 || out_err !== CHK)
      begin n_fail++; $display("FAIL illegal_class: got %h err %b want 00000013 err %b", out_word, out_err, CHK); end
    @(negedge clk);
    n_checks++; if (err_count !== (CHK ? 8'd2 : 8'd0))
      begin n_fail++; $display("FAIL err_count_two: got %0d want %0d", err_count, CHK ? 2 : 0); end
    do_clear();
    n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL err_count_clear: got %0d want 0", err_count); end
  endtask

  task automatic test_clear_wrap();
    do_clear();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_req(mk(1, 0, 0, k + 1, 0, 0, 32'(k)));
      n_checks++; if (out_valid !== 1'b1 || out_addr !== 4'(k * 4))
        begin n_fail++; $display("FAIL seq_addr%0d: v%b addr %h want %h", k, out_valid, out_addr, 4'(k * 4)); end
    end
    // clear on the same edge as the handshake of the word at 0x8
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    n_checks++; if (out_addr !== 4'h0 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL clear_wins: addr %h v%b want 0 v0", out_addr, out_valid); end
    for (int k = 0; k < 5; k++) begin
      send_req(mk(1, 0, 0, 9, 0, 0, 32'(k)));
      n_checks++; if (out_addr !== 4'((k * 4) % 16))
        begin n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", k, out_addr, 4'((k * 4) % 16)); end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        e;
    req_t        r;
    logic [3:0]  exp_addr;
    int          exp_cnt;
    bit          stalled;
    logic [31:0] pw;
    logic        pe;
    logic [3:0]  pa;
    int          cyc;
    do_clear();
    exp_addr = 4'h0; exp_cnt = 0; stalled = 1'b0; pw = '0; pe = 1'b0; pa = '0;
    cyc = 0;
    while (cyc < 1500 || (q.size() != 0 && cyc < 1600)) begin
      if (cyc < 1500) begin
        r = rand_req();
        drive(r);
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      #1;
      if (stalled) begin
        n_checks++; if (out_valid !== 1'b1 || out_word !== pw || out_err !== pe || out_addr !== pa)
          begin n_fail++; $display("FAIL rnd_stable: %h/%b@%h want %h/%b@%h", out_word, out_err, out_addr, pw, pe, pa); end
      end
      n_checks++; if (err_count !== 8'(exp_cnt))
        begin n_fail++; $display("FAIL rnd_err_count: got %0d want %0d", err_count, exp_cnt); end
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_spurious: word %h with nothing outstanding", out_word);
        end else begin
          e = q.pop_front();
          if (out_word !== e.word || out_err !== e.err || out_addr !== exp_addr) begin
            n_fail++;
            $display("FAIL rnd_word: got %h/%b@%h want %h/%b@%h", out_word, out_err, out_addr, e.word, e.err, exp_addr);
          end
          exp_addr = exp_addr + 4'd4;
          if (e.err && exp_cnt < 255) exp_cnt++;
        end
      end
      if (in_valid && in_ready) q.push_back(model(r));
      stalled = out_valid && !out_ready;
      pw = out_word; pe = out_err; pa = out_addr;
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: %0d words left, want 0", q.size()); end
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b0;
    drive(mk(1, 0, 0, 1, 0, 0, 32'd1)); in_valid = 1'b1;
    @(negedge clk);
    drive(mk(1, 0, 0, 2, 0, 0, 32'd2));
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_addr !== 4'h0)
      begin n_fail++; $display("FAIL rst_midstall: v%b rdy %b addr %h want v0 rdy 1 addr 0", out_valid, in_ready, out_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_discard: v%b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_lui();
    test_backpressure();
    test_errors();
    test_clear_wrap();
    test_random();
    test_reset_midstall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
